// File: rtl/nr_div_pkg.sv
// ---------------------------------------------------------------------------
// nr_div_pkg
// Shared definitions for the non-restoring divider:
//   - default WIDTH/STEPS values used by nr_divider
//   - controller state enumeration
//   - clog2() for sizing the iteration counter
//   - iter_count() giving the number of RUN cycles for a WIDTH/STEPS pair
// No ports (package).
// ---------------------------------------------------------------------------
package nr_div_pkg;

  localparam int NR_DEF_WIDTH = 1025;
  localparam int NR_DEF_STEPS = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } nr_state_e;

  // Smallest r with 2**r >= value; used for counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Number of RUN cycles: each cycle retires STEPS quotient bits.
  // STEPS is expected to divide WIDTH exactly.
  function automatic int iter_count(input int width, input int steps);
    return width / steps;
  endfunction

endpackage

// File: rtl/nr_divider_if.sv
// ---------------------------------------------------------------------------
// nr_divider_if
// Bundles both valid/ready handshakes of the divider.
//   in_valid/in_ready    : operand handshake (dividend, divisor)
//   out_valid/out_ready  : result handshake (quotient, remainder, div_zero)
// Modports:
//   slave  - the divider itself
//   master - the block that issues operands and consumes results
// ---------------------------------------------------------------------------
interface nr_divider_if #(
  parameter int WIDTH = 1025
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/nr_div_step.sv
// ---------------------------------------------------------------------------
// nr_div_step
// One combinational non-restoring division iteration.
//   a_in  [WIDTH:0]   partial remainder, two's complement
//   q_in  [WIDTH-1:0] dividend/quotient shift register
//   m     [WIDTH-1:0] divisor (unsigned, zero-extended internally)
//   a_out [WIDTH:0]   updated partial remainder
//   q_out [WIDTH-1:0] shifted register with new quotient bit in bit 0
// ---------------------------------------------------------------------------
import nr_div_pkg::*;

module nr_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] a_shift;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] a_next;

  // The add/subtract decision uses the sign of A before the shift. After the
  // shift the intermediate can exceed the signed range of WIDTH+1 bits, but
  // the sum A+/-M always lands back in [-M, M), so modular arithmetic in
  // WIDTH+1 bits still yields the exact partial remainder.
  always_comb begin
    a_shift = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
    m_ext   = {1'b0, m};
    if (a_in[WIDTH]) begin
      a_next = a_shift + m_ext;
    end else begin
      a_next = a_shift - m_ext;
    end
  end

  assign a_out = a_next;
  assign q_out = {q_in[WIDTH-2:0], ~a_next[WIDTH]};

endmodule

// File: rtl/nr_divider.sv
// ---------------------------------------------------------------------------
// nr_divider
// Unsigned non-restoring divider, STEPS quotient bits per clock.
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - nr_divider_if.slave:
//            in_valid/in_ready, dividend, divisor      (operand side)
//            out_valid/out_ready, quotient, remainder,
//            div_zero                                  (result side)
// Flow: IDLE -accept-> RUN (ITER cycles) -> FIX -> DONE -consume-> IDLE.
// A zero divisor skips RUN/FIX and is resolved one cycle after accept.
// ---------------------------------------------------------------------------
import nr_div_pkg::*;

module nr_divider #(
  parameter int WIDTH = NR_DEF_WIDTH,
  parameter int STEPS = NR_DEF_STEPS
) (
  input  logic         clk,
  input  logic         rst,
  nr_divider_if.slave  bus
);

  localparam int ITER = iter_count(WIDTH, STEPS);
  localparam int CW   = clog2(ITER + 1);

  nr_state_e        state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   a_fix;

  logic [WIDTH:0]   a_chain [STEPS+1];
  logic [WIDTH-1:0] q_chain [STEPS+1];

  // STEPS iterations are chained combinationally so one RUN cycle retires
  // STEPS quotient bits.
  assign a_chain[0] = a_q;
  assign q_chain[0] = q_q;

  for (genvar s = 0; s < STEPS; s++) begin : g_step
    nr_div_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .a_in  (a_chain[s]),
      .q_in  (q_chain[s]),
      .m     (m_q),
      .a_out (a_chain[s+1]),
      .q_out (q_chain[s+1])
    );
  end

  // Final correction: a negative partial remainder is restored by adding M.
  assign a_fix = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;

  // Next-state and datapath update. Operands are only looked at in IDLE, so
  // in_valid and operand values are ignored while a division is in flight.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_d   = bus.dividend;
          m_d   = bus.divisor;
          a_d   = '0;
          cnt_d = CW'(ITER);
          if (bus.divisor == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        a_d   = a_chain[STEPS];
        q_d   = q_chain[STEPS];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quotient_d  = q_q;
        remainder_d = a_fix[WIDTH-1:0];
        div_zero_d  = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        // Entering DONE with out_valid low only happens for a zero divisor:
        // the saturated result is published on this first DONE cycle. The
        // consume edge is only honoured once out_valid is actually high.
        if (!out_valid_q) begin
          quotient_d  = '1;
          remainder_d = q_q;
          div_zero_d  = 1'b1;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state lives here; reset aborts any operation in progress and no
  // partial result is left visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_nr_divider.sv
// ---------------------------------------------------------------------------
// tb_nr_divider
// Two divider instances: a narrow one (WIDTH=8, STEPS=1, 9-cycle latency)
// for directed cases, and a wide one (WIDTH=1024, STEPS=4, 257-cycle
// latency) for large-operand cases. A per-instance model predicts handshake
// timing and results from plain division and is compared against the DUT on
// every falling edge; directed calls also pin literal expectations.
// ---------------------------------------------------------------------------
module tb_nr_divider;

  localparam int W8 = 8;
  localparam int S8 = 1;
  localparam int WW = 1024;
  localparam int SW = 4;

  typedef logic [WW-1:0] wide_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nCompared = 0;
  int nFailed   = 0;

  nr_divider_if #(.WIDTH(W8)) bus8 ();
  nr_divider_if #(.WIDTH(WW)) busw ();

  nr_divider #(.WIDTH(W8), .STEPS(S8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  nr_divider #(.WIDTH(WW), .STEPS(SW)) dutw (
    .clk (clk),
    .rst (rst),
    .bus (busw)
  );

  always #5 clk = ~clk;

  // Model state per instance: 0 idle, 1 busy (mRem edges to go), 2 result held.
  int    mMode [2];
  int    mRem  [2];
  wide_t mQ    [2];
  wide_t mR    [2];
  logic  mDz   [2];
  wide_t eQ    [2];
  wide_t eR    [2];
  logic  eDz   [2];

  // One comparison: counts it, reports low 96 bits and highest differing bit.
  task automatic checkValue(input string name, input wide_t act, input wide_t req);
    int diffBit;
    nCompared++;
    if (act !== req) begin
      diffBit = -1;
      for (int b = 0; b < WW; b++) begin
        if (act[b] !== req[b]) diffBit = b;
      end
      nFailed++;
      $display("[TB] FAIL %s: got %0h required %0h (low 96 bits, top diff bit %0d) t=%0t",
               name, act[95:0], req[95:0], diffBit, $time);
    end
  endtask

  task automatic getOuts(input int idx, output logic ir, output logic ov, output logic dz,
                         output wide_t q, output wide_t r);
    if (idx == 0) begin
      ir = bus8.in_ready; ov = bus8.out_valid; dz = bus8.div_zero;
      q = wide_t'(bus8.quotient); r = wide_t'(bus8.remainder);
    end else begin
      ir = busw.in_ready; ov = busw.out_valid; dz = busw.div_zero;
      q = busw.quotient; r = busw.remainder;
    end
  endtask

  task automatic getIns(input int idx, output logic iv, output wide_t n, output wide_t d,
                        output logic ordy);
    if (idx == 0) begin
      iv = bus8.in_valid; n = wide_t'(bus8.dividend); d = wide_t'(bus8.divisor);
      ordy = bus8.out_ready;
    end else begin
      iv = busw.in_valid; n = busw.dividend; d = busw.divisor; ordy = busw.out_ready;
    end
  endtask

  task automatic setInputs(input int idx, input logic iv, input wide_t n, input wide_t d);
    if (idx == 0) begin
      bus8.in_valid = iv; bus8.dividend = n[W8-1:0]; bus8.divisor = d[W8-1:0];
    end else begin
      busw.in_valid = iv; busw.dividend = n; busw.divisor = d;
    end
  endtask

  task automatic setOutReady(input int idx, input logic v);
    if (idx == 0) bus8.out_ready = v;
    else          busw.out_ready = v;
  endtask

  function automatic int latencyOf(input int idx, input wide_t d);
    if (d == '0) return 1;
    return ((idx == 0) ? (W8 / S8) : (WW / SW)) + 1;
  endfunction

  // Reference result straight from the arithmetic definition.
  task automatic modelResult(input int idx, input wide_t n, input wide_t d,
                             output wide_t q, output wide_t r, output logic dz);
    wide_t allOnes;
    allOnes = (idx == 0) ? wide_t'(8'hFF) : {WW{1'b1}};
    if (d == '0) begin
      q = allOnes; r = n; dz = 1'b1;
    end else begin
      q = n / d; r = n % d; dz = 1'b0;
    end
  endtask

  // Outputs are checked against the model, then the model is advanced using
  // the inputs that the next rising edge will sample.
  always @(negedge clk) begin : compareProc
    logic ir, ov, dz, iv, ordy;
    wide_t q, r, n, d;
    for (int i = 0; i < 2; i++) begin
      getOuts(i, ir, ov, dz, q, r);
      getIns(i, iv, n, d, ordy);
      if (rst) begin
        mMode[i] = 0; mRem[i] = 0; mQ[i] = '0; mR[i] = '0; mDz[i] = 1'b0;
      end
      checkValue($sformatf("u%0d in_ready", i),  wide_t'(ir), wide_t'(mMode[i] == 0));
      checkValue($sformatf("u%0d out_valid", i), wide_t'(ov), wide_t'(mMode[i] == 2));
      checkValue($sformatf("u%0d div_zero", i),  wide_t'(dz), wide_t'(mDz[i]));
      checkValue($sformatf("u%0d quotient", i),  q, mQ[i]);
      checkValue($sformatf("u%0d remainder", i), r, mR[i]);
      if (!rst) begin
        case (mMode[i])
          0: if (iv === 1'b1) begin
               modelResult(i, n, d, eQ[i], eR[i], eDz[i]);
               mRem[i]  = latencyOf(i, d);
               mMode[i] = 1;
             end
          1: begin
               mRem[i] = mRem[i] - 1;
               if (mRem[i] == 0) begin
                 mMode[i] = 2; mQ[i] = eQ[i]; mR[i] = eR[i]; mDz[i] = eDz[i];
               end
             end
          default: if (ordy === 1'b1) mMode[i] = 0;
        endcase
      end
    end
  end

  // Issue one operation, wait for its result, hold it for 'hold' cycles and
  // consume it. With 'overlap' set, in_valid is raised during the consume
  // edge with different operands, which must not be accepted.
  task automatic applyStimulus(input int idx, input wide_t n, input wide_t d, input int hold,
                               input bit overlap, input int lat, input bit pin,
                               input wide_t pq, input wide_t pr, input logic pdz);
    logic ir, ov, dz;
    wide_t q, r;
    bit ok;
    int edges;
    setInputs(idx, 1'b1, n, d);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      getOuts(idx, ir, ov, dz, q, r);
      @(posedge clk);
      #1;
      ok = (ir === 1'b1);
    end
    checkValue($sformatf("u%0d accept", idx), wide_t'(ok), wide_t'(1));
    if (!ok) begin
      setInputs(idx, 1'b0, n, d);
      return;
    end
    setInputs(idx, 1'b0, n ^ randWide(WW), d ^ randWide(WW));
    ok = 0;
    edges = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      #1;
      edges++;
      getOuts(idx, ir, ov, dz, q, r);
      ok = (ov === 1'b1);
    end
    checkValue($sformatf("u%0d latency", idx), wide_t'(ok ? edges : -1), wide_t'(lat));
    if (!ok) return;
    if (pin) begin
      checkValue($sformatf("u%0d pinned quotient", idx), q, pq);
      checkValue($sformatf("u%0d pinned remainder", idx), r, pr);
      checkValue($sformatf("u%0d pinned div_zero", idx), wide_t'(dz), wide_t'(pdz));
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    setOutReady(idx, 1'b1);
    if (overlap) setInputs(idx, 1'b1, ~n, d + 1);
    @(posedge clk);
    #1;
    setOutReady(idx, 1'b0);
    if (overlap) setInputs(idx, 1'b0, n, d);
  endtask

  function automatic wide_t randWide(input int bits);
    wide_t v;
    for (int k = 0; k < WW / 32; k++) v[k*32 +: 32] = $urandom;
    if (bits < WW) v = v & ({WW{1'b1}} >> (WW - bits));
    return v;
  endfunction

  // Abort an 8-bit division once its iteration counter has reached 4.
  task automatic resetMidOp();
    logic ir, ov, dz;
    wide_t q, r;
    setInputs(0, 1'b1, 123, 4);
    @(posedge clk);
    #1;
    setInputs(0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    getOuts(0, ir, ov, dz, q, r);
    checkValue("reset in_ready", wide_t'(ir), wide_t'(1));
    checkValue("reset out_valid", wide_t'(ov), wide_t'(0));
    checkValue("reset quotient", q, wide_t'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    wide_t n, d, allOnes, half;
    int nb, db;
    setInputs(0, 1'b0, 0, 0);
    setInputs(1, 1'b0, 0, 0);
    setOutReady(0, 1'b0);
    setOutReady(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] narrow directed cases");
    applyStimulus(0, 100, 7,   0, 0, 9, 1, 14,  2,   1'b0);
    applyStimulus(0, 5,   0,   0, 0, 1, 1, 255, 5,   1'b1);
    applyStimulus(0, 3,   10,  0, 1, 9, 1, 0,   3,   1'b0);
    applyStimulus(0, 255, 1,   1, 0, 9, 1, 255, 0,   1'b0);
    applyStimulus(0, 200, 200, 0, 1, 9, 1, 1,   0,   1'b0);
    applyStimulus(0, 0,   9,   2, 0, 9, 1, 0,   0,   1'b0);

    $display("[TB] stall and back-to-back");
    applyStimulus(0, 77,  5,  20, 1, 9, 1, 15, 2,  1'b0);
    applyStimulus(0, 250, 16, 0,  0, 9, 1, 15, 10, 1'b0);

    $display("[TB] reset during RUN");
    resetMidOp();
    applyStimulus(0, 50, 6, 0, 0, 9, 1, 8, 2, 1'b0);

    $display("[TB] wide directed cases");
    allOnes = {WW{1'b1}};
    half    = {WW{1'b1}} >> (WW / 2);
    applyStimulus(1, allOnes, 1, 0, 0, 257, 1, allOnes, 0, 1'b0);
    applyStimulus(1, allOnes, half + 1, 1, 1, 257, 1, half, half, 1'b0);
    applyStimulus(1, 5, allOnes, 0, 0, 257, 1, 0, 5, 1'b0);
    applyStimulus(1, allOnes, allOnes, 0, 0, 257, 1, 1, 0, 1'b0);
    applyStimulus(1, 12345, 0, 0, 0, 1, 1, allOnes, 12345, 1'b1);

    $display("[TB] wide random cases");
    for (int k = 0; k < 40; k++) begin
      nb = $urandom_range(WW, 1);
      db = (k % 5 == 4) ? $urandom_range(WW, 1) : $urandom_range(nb, 1);
      n  = randWide(nb);
      d  = randWide(db);
      if (d == '0) d = 1;
      applyStimulus(1, n, d, k % 3, k[0], 257, 0, 0, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
